// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM scheduler.
package sram_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam int NUM_PORTS = 2;
  localparam int LOCK_CW   = 8;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick: prio wins a tie, a lone request always wins.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 prio_i,
  output logic                 win_o,
  output logic                 vld_o
);

  always_comb begin
    vld_o = |req_i;
    win_o = req_i[1];
    if (&req_i) win_o = prio_i;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin scheduler of two requesters onto one SRAM: gnt 1 cycle after req, read data 2 cycles after, one access per 2 cycles.
// Requesters hold req until gnt. Bounded grant locking is compiled in with SRAM_ARB_LOCK_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int SIZE     = 256,
  parameter  int MAX_LOCK = 8,
  localparam int AW       = $clog2(SIZE)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic          m0_lock,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic          m1_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  state_e                 state_q, state_d;
  logic                   prio_q, prio_d;
  logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d;
  logic                   sram_we_q, sram_we_d;
  logic [AW-1:0]          sram_addr_q, sram_addr_d;
  logic [31:0]            sram_wdata_q, sram_wdata_d;

  logic [NUM_PORTS-1:0]   req;
  logic                   arb_prio, arb_win, arb_vld;
  logic                   win_we;
  logic [AW-1:0]          win_addr;
  logic [31:0]            win_wdata;

  assign req       = {m1_req, m0_req};
  assign win_we    = arb_win ? m1_we    : m0_we;
  assign win_addr  = arb_win ? m1_addr  : m0_addr;
  assign win_wdata = arb_win ? m1_wdata : m0_wdata;

  rr_arb2 u_rr_arb2 (
    .req_i  (req),
    .prio_i (arb_prio),
    .win_o  (arb_win),
    .vld_o  (arb_vld)
  );

`ifdef SRAM_ARB_LOCK_EN
  logic               lock_vld_q, lock_vld_d;
  logic               lock_port_q, lock_port_d;
  logic [LOCK_CW-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic               lock_hold, win_lock;

  // A held lock steers the tie-break; a lone request from the other port releases it.
  assign lock_hold    = lock_vld_q && req[lock_port_q];
  assign arb_prio     = lock_hold ? lock_port_q : prio_q;
  assign win_lock     = arb_win ? m1_lock : m0_lock;
  assign lock_cnt_inc = lock_hold ? lock_cnt_q + LOCK_CW'(1) : LOCK_CW'(1);

  always_comb begin
    lock_vld_d  = lock_vld_q;
    lock_port_d = lock_port_q;
    lock_cnt_d  = lock_cnt_q;
    if (state_q == IDLE) begin
      lock_vld_d  = arb_vld && win_lock && (lock_cnt_inc < LOCK_CW'(MAX_LOCK));
      lock_port_d = arb_win;
      lock_cnt_d  = lock_vld_d ? lock_cnt_inc : '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lock_vld_q  <= 1'b0;
      lock_port_q <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      lock_vld_q  <= lock_vld_d;
      lock_port_q <= lock_port_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end
`else
  logic unused_lock;

  assign arb_prio    = prio_q;
  assign unused_lock = ^{m0_lock, m1_lock, MAX_LOCK[0]};
`endif

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    gnt_d        = '0;
    rvalid_d     = '0;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d      = ISSUE;
          gnt_d        = arb_win ? 2'b10 : 2'b01;
          prio_d       = ~arb_win;
          sram_we_d    = win_we;
          sram_addr_d  = win_addr;
          sram_wdata_d = win_wdata;
        end
      end
      ISSUE: begin
        // Requests are ignored here; the SRAM samples the command at this edge.
        state_d  = IDLE;
        rvalid_d = gnt_q & {NUM_PORTS{~sram_we_q}};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign m0_gnt     = gnt_q[0];
  assign m1_gnt     = gnt_q[1];
  assign m0_rvalid  = rvalid_q[0];
  assign m1_rvalid  = rvalid_q[1];
  assign m0_rdata   = rvalid_q[0] ? sram_rdata : '0;
  assign m1_rdata   = rvalid_q[1] ? sram_rdata : '0;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table, multi-cycle corner sequences and a randomized run against a transaction-level model.
module tb_sram_port_arbiter;

  localparam int SIZE = 256;
  localparam int AW   = 8;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  sram_port_arbiter #(.SIZE(SIZE), .MAX_LOCK(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural single-port SRAM with one-cycle registered read.
  logic [31:0] mem [SIZE];
  logic        pre_go;

  always @(posedge HCLK) begin
    if (pre_go) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= 32'h1000_0000 + i;
      mem[5] <= 32'hDEAD_BEEF;
      mem[7] <= 32'h0;
    end else begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      sram_rdata <= mem[sram_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_lock = 0; m1_lock = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    HRESETn = 0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1;
  endtask

  typedef struct {
    bit          r0, r1, we0, we1;
    logic [7:0]  a0, a1;
    logic [31:0] d0, d1;
    int          g0, g1;       // cycle of gnt relative to req, -1 = none
    logic [31:0] x0, x1;       // expected read data
  } vec_t;

  vec_t tbl [8];

  task automatic run_row(input int idx, input vec_t v);
    int g0 = -1, g1 = -1, c0 = -1, c1 = -1, stray = 0;
    int e0, e1;
    logic [31:0] d0 = '0, d1 = '0;
    m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
    m0_lock = 0; m1_lock = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge HCLK);
      if (m0_gnt && m1_gnt) stray++;
      if (m0_gnt) begin if (g0 < 0) g0 = k; else stray++; m0_req = 0; end
      if (m1_gnt) begin if (g1 < 0) g1 = k; else stray++; m1_req = 0; end
      if (m0_rvalid) begin c0 = k; d0 = m0_rdata; end
      if (m1_rvalid) begin c1 = k; d1 = m1_rdata; end
      if (!m0_rvalid && m0_rdata != 0) stray++;
      if (!m1_rvalid && m1_rdata != 0) stray++;
    end
    e0 = (v.r0 && !v.we0) ? v.g0 + 1 : -1;
    e1 = (v.r1 && !v.we1) ? v.g1 + 1 : -1;
    check($sformatf("row%0d_gnt0_cyc", idx), 128'(g0), 128'(v.g0));
    check($sformatf("row%0d_gnt1_cyc", idx), 128'(g1), 128'(v.g1));
    check($sformatf("row%0d_rv0_cyc", idx), 128'(c0), 128'(e0));
    check($sformatf("row%0d_rv1_cyc", idx), 128'(c1), 128'(e1));
    if (e0 >= 0) check($sformatf("row%0d_rdata0", idx), 128'(d0), 128'(v.x0));
    if (e1 >= 0) check($sformatf("row%0d_rdata1", idx), 128'(d1), 128'(v.x1));
    check($sformatf("row%0d_stray", idx), 128'(stray), 128'(0));
  endtask

  // Both ports read continuously; records the winner of each grant (bit k = port of grant k).
  task automatic run_grants(input bit r0, input bit r1, input bit l0, input bit l1, input int n,
                            output logic [15:0] wins, output int last_cyc);
    int got = 0, cyc = 0;
    wins = '0; last_cyc = -1;
    m0_req = r0; m1_req = r1; m0_we = 0; m1_we = 0; m0_lock = l0; m1_lock = l1;
    m0_addr = 8'd1; m1_addr = 8'd2;
    while (got < n && cyc < 4 * n + 8) begin
      @(negedge HCLK);
      cyc++;
      if (m0_gnt || m1_gnt) begin
        wins[got] = m1_gnt;
        got++;
        last_cyc = cyc;
      end
    end
    clear_inputs();
    repeat (4) @(negedge HCLK);
  endtask

  // Transaction-level model state for the randomized run.
  logic [31:0] mem_m [SIZE];
  logic [1:0]  x_gnt [4];
  logic [1:0]  x_rv  [4];
  logic [31:0] x_rd  [4];
  logic        x_we  [4];
  logic [7:0]  x_addr[4];
  logic [31:0] x_wd  [4];
  bit          pend [2];
  bit          pwe  [2];
  logic [7:0]  padr [2];
  logic [31:0] pwd  [2];

  initial begin : main
    logic [15:0] wins;
    int          last_cyc, pulses, free_c, last_w, s, s1, s2;
    bit          w;
    logic [127:0] act_v, exp_v;

    tbl[0] = '{1, 0, 0, 0, 8'd5,  8'd0,   32'h0, 32'h0,          1, -1, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{0, 1, 0, 1, 8'd0,  8'd3,   32'h0, 32'h1234_5678, -1,  1, 32'h0,         32'h0};
    tbl[2] = '{1, 0, 0, 0, 8'd3,  8'd0,   32'h0, 32'h0,          1, -1, 32'h1234_5678, 32'h0};
    tbl[3] = '{1, 1, 0, 0, 8'd10, 8'd11,  32'h0, 32'h0,          3,  1, 32'h1000_000A, 32'h1000_000B};
    tbl[4] = '{1, 1, 0, 1, 8'd20, 8'd20,  32'h0, 32'hCAFE_F00D,  3,  1, 32'hCAFE_F00D, 32'h0};
    tbl[5] = '{1, 1, 1, 0, 8'd21, 8'd21,  32'h55AA_55AA, 32'h0,  3,  1, 32'h0,         32'h1000_0015};
    tbl[6] = '{0, 1, 0, 0, 8'd0,  8'd21,  32'h0, 32'h0,         -1,  1, 32'h0,         32'h55AA_55AA};
    tbl[7] = '{1, 1, 0, 0, 8'd0,  8'd255, 32'h0, 32'h0,          1,  3, 32'h1000_0000, 32'h1000_00FF};

    clear_inputs();
    HRESETn = 0;
    pre_go  = 1;
    @(negedge HCLK);
    pre_go  = 0;
    @(negedge HCLK);
    check("reset_outs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_we, sram_addr, sram_wdata, m0_rdata, m1_rdata}, '0);
    HRESETn = 1;
    @(negedge HCLK);
    check("post_reset_idle", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_we, m0_rdata, m1_rdata}, '0);

    for (int i = 0; i < 8; i++) run_row(i, tbl[i]);

    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge HCLK);
      if (m0_gnt || m1_gnt || m0_rvalid || m1_rvalid || sram_we) pulses++;
    end
    check("idle_pulses", 128'(pulses), 128'(0));
    check("idle_addr_hold", 128'(sram_addr), 128'(8'd255));

    do_reset();
    run_grants(1, 1, 0, 0, 6, wins, last_cyc);
    check("contend_order", 128'(wins), 128'(16'b10_1010));
    check("contend_last_cyc", 128'(last_cyc), 128'(11));

    do_reset();
    run_grants(1, 1, 0, 1, 7, wins, last_cyc);
`ifdef SRAM_ARB_LOCK_EN
    check("lock_order", 128'(wins), 128'(16'b101_1110));
`else
    check("lock_ignored_order", 128'(wins), 128'(16'b010_1010));
`endif
    check("lock_last_cyc", 128'(last_cyc), 128'(13));

    m0_req = 1; m0_we = 1; m0_addr = 8'd7; m0_wdata = 32'hAAAA_5555;
    @(negedge HCLK);
    check("rst_issue_gnt", 128'(m0_gnt), 128'(1));
    check("rst_issue_we", 128'(sram_we), 128'(1));
    #2 HRESETn = 0;
    clear_inputs();
    #1 check("rst_async_clear", 128'({sram_we, m0_gnt, m1_gnt}), 128'(0));
    @(negedge HCLK);
    check("rst_write_dropped", 128'(mem[7]), 128'(0));
    check("rst_vals", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_we, sram_addr, sram_wdata, m0_rdata, m1_rdata}, '0);
    HRESETn = 1;
    run_grants(1, 1, 0, 0, 2, wins, last_cyc);
    check("rst_then_contend", 128'(wins), 128'(16'b10));

    do_reset();
    for (int i = 0; i < SIZE; i++) mem_m[i] = mem[i];
    for (int i = 0; i < 4; i++) begin
      x_gnt[i] = '0; x_rv[i] = '0; x_rd[i] = '0; x_we[i] = 0; x_addr[i] = '0; x_wd[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pwe[p] = 0; padr[p] = '0; pwd[p] = '0;
    end
    free_c = 0;
    last_w = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge HCLK);
      s = c % 4;
      exp_v = {19'h0, x_gnt[s][1], x_gnt[s][0], x_rv[s][1], x_rv[s][0], x_we[s], x_addr[s], x_wd[s],
               x_rv[s][0] ? x_rd[s] : 32'h0, x_rv[s][1] ? x_rd[s] : 32'h0};
      act_v = {19'h0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, sram_we,
               (x_gnt[s] != 0) ? sram_addr : 8'h0,
               (x_gnt[s] != 0 && x_we[s]) ? sram_wdata : 32'h0,
               m0_rdata, m1_rdata};
      check($sformatf("rnd_cyc%0d", c), act_v, exp_v);
      x_gnt[s] = '0; x_rv[s] = '0; x_rd[s] = '0; x_we[s] = 0; x_addr[s] = '0; x_wd[s] = '0;

      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          pwe[p]  = 1'($urandom_range(0, 1));
          padr[p] = 8'($urandom_range(0, 15));
          pwd[p]  = $urandom;
        end
      end
      m0_req = pend[0]; m0_we = pwe[0]; m0_addr = padr[0]; m0_wdata = pwd[0];
      m1_req = pend[1]; m1_we = pwe[1]; m1_addr = padr[1]; m1_wdata = pwd[1];
`ifdef SRAM_ARB_LOCK_EN
      m0_lock = 0; m1_lock = 0;
`else
      m0_lock = 1'($urandom_range(0, 1)); m1_lock = 1'($urandom_range(0, 1));
`endif

      // Accesses are serialised: the port that did not win last time wins a tie.
      if (c >= free_c && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? (last_w == 0) : pend[1];
        last_w = int'(w);
        free_c = c + 2;
        s1 = (c + 1) % 4;
        s2 = (c + 2) % 4;
        x_gnt[s1][w] = 1'b1;
        x_we[s1]     = pwe[w];
        x_addr[s1]   = padr[w];
        if (pwe[w]) begin
          x_wd[s1] = pwd[w];
          mem_m[padr[w]] = pwd[w];
        end else begin
          x_rv[s2][w] = 1'b1;
          x_rd[s2]    = mem_m[padr[w]];
        end
        pend[w] = 0;
      end
    end
    clear_inputs();
    repeat (4) @(negedge HCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
